serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It is the additive counterpart to the team's one-bit combinational subtractor cell. It sits in the arithmetic datapath where area matters more than throughput. Operands enter and results leave over valid/ready handshakes.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 2 to 64.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset; asynchronous, active-low.
- in_valid, input, 1: operands a, b and cin are valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: augend.
- b, input, WIDTH: addend.
- cin, input, 1: carry into bit 0.
- out_valid, output, 1: sum, cout and ovf are valid.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: a + b + cin, modulo 2^WIDTH.
- cout, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: two's-complement overflow, equal to the carry into the MSB XOR cout.

## Operation
- States: IDLE, RUN, DONE.
- Accept:
  - in_ready = (state == IDLE) AND rst_n.
  - An input handshake is in_valid AND in_ready at a rising edge.
  - On handshake: load shift registers A <= a and B <= b; carry register <= cin; bit counter <= 0; go to RUN.
- RUN, each cycle:
  - The full_adder cell combines A[0], B[0] and the carry register.
  - A and B shift right by 1.
  - The sum bit shifts into sum[WIDTH-1] while the sum register shifts right.
  - The carry register takes the cell's carry output.
  - The counter increments.
  - On the cycle where counter == WIDTH-1, the carry register value is captured into an msb_cin register before being overwritten; go to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout (the carry register) and ovf (msb_cin XOR carry) are held stable.
  - On out_valid AND out_ready: go to IDLE.
- Operands presented while in RUN or DONE are ignored, because in_ready is low.
- Width rules:
  - All internal arithmetic is one bit wide.
  - The counter is $clog2(WIDTH) bits.
  - Results are never sign-extended.
- Reset, asserted at any time including mid-RUN or in DONE: an immediate return to IDLE with these values:
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 0.
  - Internal shift registers, counter and carry are cleared.
  - No partial result is ever presented.

## Timing
- Input handshake at edge T: RUN occupies the cycles after edges T through T+WIDTH-1, and out_valid rises after edge T+WIDTH.
- Latency is WIDTH+1 cycles from the accept cycle to the first out_valid cycle.
- Output handshake at edge U: IDLE follows, with in_ready high in the next cycle.
- Minimum initiation interval: WIDTH+2 cycles.
- Output backpressure:
  - out_valid stays high, and sum/cout/ovf do not change, until out_ready is sampled high.
  - There is no timeout.
- out_ready while out_valid is low has no effect.
- in_valid does not need to be held after the handshake.
- in_ready is a combinational decode of the state register, gated by rst_n. It has no combinational dependency on in_valid or out_ready.
- In the first cycle after rst_n deasserts, in_ready = 1.

## Structure
- Shared package arith_pkg holds:
  - typedef enum logic [1:0] serial_state_t {IDLE, RUN, DONE};
  - localparam SERIAL_WIDTH_DEFAULT = 8.
- Sub-module full_adder: purely combinational one-bit cell with inputs a, b, cin and outputs sum = a^b^cin, cout = a&b | cin&(a^b). It is instantiated once and reused every RUN cycle.
- The top level holds the FSM, shift registers, counter and handshake logic.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> out_valid 9 cycles after accept; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0; in_ready low from accept until the output handshake.
- Backpressure with a=0x12, b=0x34, cin=0:
  - Hold out_ready=0 for 5 cycles in DONE, and drive in_valid=1 with other operands throughout.
  - Required: sum stays 0x46 and stable; the second operand set is not accepted until after the output handshake.
- Reset mid-operation:
  - Assert rst_n=0 after 3 RUN cycles -> all outputs 0 immediately (asynchronously), with no out_valid pulse.
  - After release, a new operation a=0x01, b=0x01 -> sum=0x02.
- Back-to-back: three operations with in_valid and out_ready held high -> accepts spaced exactly WIDTH+2 cycles apart, and results in order.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and defaults.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  localparam int unsigned SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_half;

  // Sum and carry of a single bit position.
  assign w_half = a ^ b;
  assign sum    = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, valid/ready on both sides.
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned        CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_t    r_state;
  serial_state_t    w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_msb_cin;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_hs;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_out;

  // Single adder cell reused for every bit position.
  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_sum_bit),
    .cout (w_carry_out)
  );

  // Ready is a pure state decode, forced low while reset is held.
  assign in_ready = (r_state == IDLE) && rst_n;
  assign w_in_hs  = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_in_hs)   w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand load, per-bit shift and carry/counter update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_cnt     <= '0;
    end else if (w_in_hs) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
      r_carry <= w_carry_out;
      r_cnt   <= r_cnt + CNT_W'(1);
      // Carry into the MSB is needed later for overflow detection.
      if (w_last) begin
        r_msb_cin <= r_carry;
      end
    end
  end

  // Result outputs come straight from registers held stable in DONE.
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_carry;
  assign ovf       = r_msb_cin ^ r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard testbench for serial_adder (WIDTH = 8).
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: wide add, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Present operands at a falling edge and hold until accepted (bounded).
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) sb.push_back(model(x, y, ci));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; report latency and in_ready-high cycles seen.
  task automatic get_result(output res_t obs, output int lat, output int rdy_hi, output bit ok);
    lat = 0; rdy_hi = 0; ok = 1'b0;
    for (int i = 1; i <= 4 * W; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      if (in_ready) rdy_hi++;
    end
    obs = {sum, cout, ovf};
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  function automatic res_t pop_exp();
    if (sb.size() != 0) return sb.pop_front();
    return '1;
  endfunction

  // Full transaction: send, wait, pop expectation, then acknowledge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        output res_t obs, output res_t exp, output int lat,
                        output int rdy_hi, output bit rdy_done, output bit ok);
    bit ok_in, ok_out;
    send(x, y, ci, ok_in);
    get_result(obs, lat, rdy_hi, ok_out);
    rdy_done = in_ready;
    exp = pop_exp();
    ok = ok_in && ok_out;
    ack();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b rdy=%b sum=%h c=%b o=%b want all 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    res_t obs, exp;
    int lat, rh;
    bit rd, ok;
    run_op(8'h5A, 8'h3C, 1'b0, obs, exp, lat, rh, rd, ok);
    checks++;
    if (!ok || lat != W + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d (ok=%b) want %0d", lat, ok, W + 1);
    end
    checks++;
    if (obs !== exp || obs !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_result: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_carry();
    res_t obs, exp;
    int lat, rh;
    bit rd, ok;
    run_op(8'hFF, 8'h01, 1'b0, obs, exp, lat, rh, rd, ok);
    checks++;
    if (!ok || obs !== exp || obs !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_ff_01: got %h want %h ok=%b", obs, exp, ok);
    end
    run_op(8'h80, 8'h80, 1'b0, obs, exp, lat, rh, rd, ok);
    checks++;
    if (!ok || obs !== exp || obs !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL carry_80_80: got %h want %h ok=%b", obs, exp, ok);
    end
  endtask

  task automatic test_cin();
    res_t obs, exp;
    int lat, rh;
    bit rd, ok;
    run_op(8'h00, 8'h00, 1'b1, obs, exp, lat, rh, rd, ok);
    checks++;
    if (!ok || obs !== exp || obs !== {8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cin_result: got %h want %h ok=%b", obs, exp, ok);
    end
    checks++;
    if (rh != 0 || rd !== 1'b0) begin
      errors++;
      $display("FAIL cin_ready_busy: got run_high=%0d done_ready=%b want 0 and 0", rh, rd);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cin_ready_after_ack: got rdy=%b ov=%b want 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    res_t obs, exp;
    int lat, rh;
    bit ok;
    send(8'h12, 8'h34, 1'b0, ok);
    a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    get_result(obs, lat, rh, ok);
    exp = pop_exp();
    checks++;
    if (!ok || rh != 0 || obs !== exp || obs !== {8'h46, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_first: got %h want %h ok=%b run_ready=%0d", obs, exp, ok, rh);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got ov=%b rdy=%b sum=%h want ov=1 rdy=0 sum=46", i, out_valid, in_ready, sum);
      end
      @(negedge clk);
    end
    ack();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_ack: got %b want 1", in_ready);
    end
    sb.push_back(model(8'h77, 8'h11, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    get_result(obs, lat, rh, ok);
    exp = pop_exp();
    checks++;
    if (!ok || lat != W + 1 || obs !== exp || obs !== {8'h88, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_second: got %h lat=%0d want %h lat=%0d", obs, lat, exp, W + 1);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    res_t obs, exp;
    int lat, rh;
    bit rd, ok;
    send(8'h0F, 8'h0F, 1'b0, ok);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got ov=%b rdy=%b sum=%h c=%b o=%b want all 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== '0) begin
        errors++;
        $display("FAIL midreset_hold%0d: got ov=%b sum=%h want 0 0", i, out_valid, sum);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    run_op(8'h01, 8'h01, 1'b0, obs, exp, lat, rh, rd, ok);
    checks++;
    if (!ok || lat != W + 1 || obs !== exp || obs !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_next: got %h lat=%0d want %h", obs, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] opa [3];
    logic [W-1:0] opb [3];
    logic         opc [3];
    int   acc [3];
    int   k, n;
    res_t obs, exp;
    opa[0] = 8'h0F; opb[0] = 8'hF1; opc[0] = 1'b0;
    opa[1] = 8'h7F; opb[1] = 8'h01; opc[1] = 1'b1;
    opa[2] = 8'hAA; opb[2] = 8'h55; opc[2] = 1'b1;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    k = 0; n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (k < 3) begin
        in_valid = 1'b1; a = opa[k]; b = opb[k]; cin = opc[k];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc[k] = c;
        sb.push_back(model(opa[k], opb[k], opc[k]));
        k++;
      end
      if (out_valid) begin
        obs = {sum, cout, ovf};
        exp = pop_exp();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h want %h", n, obs, exp);
        end
        n++;
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (n != 3 || k != 3) begin
      errors++;
      $display("FAIL b2b_count: got results=%0d accepts=%0d want 3 3", n, k);
    end
    checks++;
    if (acc[1] - acc[0] != W + 2 || acc[2] - acc[1] != W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d want %0d", acc[1] - acc[0], acc[2] - acc[1], W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_cin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
